// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and the opcode type.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [3:0] alu_sel_t;

    localparam alu_sel_t ALU_ADD = 4'b0000;
    localparam alu_sel_t ALU_SUB = 4'b0001;
    localparam alu_sel_t ALU_MUL = 4'b0010;
    localparam alu_sel_t ALU_DIV = 4'b0011;
    localparam alu_sel_t ALU_AND = 4'b0100;
    localparam alu_sel_t ALU_OR  = 4'b0101;
    localparam alu_sel_t ALU_NOR = 4'b0110;
    localparam alu_sel_t ALU_SLL = 4'b0111;
    localparam alu_sel_t ALU_SRL = 4'b1000;

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero.
// Optional macro OPFETCH_FWD_EN: same-cycle write-to-read bypass on both ports.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Write port; reset has priority so a write-back during reset is lost.
    // Entry 0 is never written and the read path masks it anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

`ifdef OPFETCH_FWD_EN
    logic hit_a, hit_b;

    // A write landing this edge is returned to a reader in the same cycle.
    always_comb begin
        hit_a = wb_en && (wb_addr != '0) && (wb_addr == ra_addr);
        hit_b = wb_en && (wb_addr != '0) && (wb_addr == rb_addr);
    end

    // Read ports with bypass; r0 always reads zero.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != '0) ra_data = hit_a ? wb_data : regs[ra_addr];
        if (rb_addr != '0) rb_data = hit_b ? wb_data : regs[rb_addr];
    end
`else
    // Read ports return the stored value; a same-cycle write shows up next cycle.
    always_comb begin
        ra_data = '0;
        rb_data = '0;
        if (ra_addr != '0) ra_data = regs[ra_addr];
        if (rb_addr != '0) rb_data = regs[rb_addr];
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads rs/rt from the register file, picks register or
// extended immediate for b, and holds a/b/alu_sel in a one-entry buffer
// with a valid/ready handshake toward the ALU.
// Optional macro OPFETCH_FWD_EN: same-cycle write-back bypass into the read.
module operand_fetch_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int NREGS = alu_pkg::NREGS,
    parameter int AW    = alu_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    input  logic [15:0]     imm,
    input  logic            use_imm,
    input  logic            sign_ext,
    input  alu_sel_t        alu_sel_in,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output alu_sel_t        alu_sel
);

    logic [XLEN-1:0] rs_data, rt_data;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] b_next;
    logic            accept;

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs_addr),
        .rb_addr (rt_addr),
        .ra_data (rs_data),
        .rb_data (rt_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    // Handshake and operand-b selection; the buffer frees up when drained.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        imm_ext  = sign_ext ? {{(XLEN-16){imm[15]}}, imm} : {{(XLEN-16){1'b0}}, imm};
        b_next   = use_imm ? imm_ext : rt_data;
    end

    // One-entry buffer: load on accept, drop valid on a bare consume, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            alu_sel   <= ALU_ADD;
        end else if (accept) begin
            out_valid <= 1'b1;
            a         <= rs_data;
            b         <= b_next;
            alu_sel   <= alu_sel_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
